ram_initiator: RTL and testbench

Bus-master sequencer that drives the RAM port protocol: address on `bas`, MAR latch strobe `wsa`, write data on `bis` with write strobe `ws`, and read enable `we` with data returned on `bos`. It turns a valid/ready request into single-word or burst transfers with per-word write and read handshakes, so clocked logic such as a DMA engine, loader or test driver can own the RAM in place of the CPU stepper. It sits between that clocked requester and the RAM's address, input and output buses.

---
 rtl/ram_initiator.sv | 106 ++++++++++
 tb/tb_ram_initiator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_initiator.sv
// Bus-master sequencer for the RAM port: turns a valid/ready request into
// single-word or burst transfers over bas/wsa, bis/ws and we/bos.
module ram_initiator #(
  parameter int LENW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [7:0]      req_addr,
  input  logic [LENW-1:0] req_len,
  input  logic            wvalid,
  output logic            wready,
  input  logic [7:0]      wdata,
  output logic            rvalid,
  input  logic            rready,
  output logic [7:0]      rdata,
  output logic            busy,
  output logic            done,
  output logic [7:0]      bas,
  output logic            wsa,
  output logic [7:0]      bis,
  output logic            ws,
  output logic            we,
  input  logic [7:0]      bos
);

  typedef enum logic [2:0] {IDLE, SETA, WDATA, WSTB, WHOLD, RSTB, RRESP, DONE} state_t;

  state_t          state, nxt;
  logic [7:0]      addr, nxt_addr;
  logic [LENW-1:0] cnt, nxt_cnt;
  logic            dir;
  logic            advance;

  always_comb begin
    nxt      = state;
    nxt_addr = addr;
    nxt_cnt  = cnt;
    advance  = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        nxt      = SETA;
        nxt_addr = req_addr;
        nxt_cnt  = req_len;
      end
      SETA:  nxt = dir ? WDATA : RSTB;
      WDATA: if (wvalid) nxt = WSTB;
      WSTB:  nxt = WHOLD;
      WHOLD: advance = 1'b1;
      RSTB:  nxt = RRESP;
      RRESP: advance = rready;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // word finished: either close the burst or step to the next address
    if (advance) begin
      if (cnt == '0) nxt = DONE;
      else begin
        nxt      = SETA;
        nxt_addr = addr + 8'd1;
        nxt_cnt  = cnt - LENW'(1);
      end
    end
  end

  // All outputs are decoded from the next state so they change only on clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wsa       <= 1'b0;
      wready    <= 1'b0;
      ws        <= 1'b0;
      we        <= 1'b0;
      rvalid    <= 1'b0;
      bas       <= '0;
      bis       <= '0;
      rdata     <= '0;
    end else begin
      state     <= nxt;
      addr      <= nxt_addr;
      cnt       <= nxt_cnt;
      if (state == IDLE && req_valid) dir <= req_write;
      req_ready <= (nxt == IDLE);
      busy      <= (nxt != IDLE);
      done      <= (nxt == DONE);
      wsa       <= (nxt == SETA);
      wready    <= (nxt == WDATA);
      ws        <= (nxt == WSTB);
      we        <= (nxt == RSTB);
      rvalid    <= (nxt == RRESP);
      bas       <= (nxt == IDLE || nxt == DONE) ? 8'h00 : nxt_addr;
      if (state == WDATA && wvalid) bis <= wdata;
      else if (nxt != WSTB && nxt != WHOLD) bis <= '0;
      if (state == RSTB) rdata <= bos;
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator with a behavioural MAR/RAM model on the bus.
module tb_ram_initiator;
  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wvalid, wready, rvalid, rready;
  logic [7:0] wdata, rdata;
  logic       busy, done, wsa, ws, we;
  logic [7:0] bas, bis, bos;

  ram_initiator #(.LENW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .busy(busy), .done(done),
    .bas(bas), .wsa(wsa), .bis(bis), .ws(ws), .we(we), .bos(bos)
  );

  always #5 clk = ~clk;

  // RAM: MAR latched on wsa, write on ws, combinational read
  logic [7:0] mem [256];
  logic [7:0] mar;
  always @(posedge clk) begin
    if (wsa) mar <= bas;
    if (ws) mem[mar] <= bis;
  end
  assign bos = mem[mar];

  int cyc = 0, n_wsa = 0, n_ws = 0, n_we = 0, n_done = 0, n_excl = 0, n_werr = 0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    n_wsa  <= n_wsa + int'(wsa);
    n_ws   <= n_ws + int'(ws);
    n_we   <= n_we + int'(we);
    n_done <= n_done + int'(done);
    if (int'(wsa) + int'(ws) + int'(we) > 1) n_excl <= n_excl + 1;
    if (we && rvalid) n_werr <= n_werr + 1;
  end

  int compared = 0, mismatched = 0;
  int tacc, tdone, wc, rc, nrdy;
  int s_wsa, s_ws, s_we, s_done;
  logic [7:0] wq [16];
  logic [7:0] got [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, take the accept edge, land in SETA.
  task automatic start(input logic wr, input logic [7:0] a, input logic [3:0] l, input bit hold);
    req_write = wr; req_addr = a; req_len = l; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    tacc = cyc;
    tick();
    if (!hold) begin
      req_valid = 1'b0; req_addr = '0; req_len = '0; req_write = 1'b0;
    end
    chk("seta_bas", bas, a);
    chk("seta_wsa", wsa, 1);
  endtask

  // Run the transfer to DONE, feeding write data and collecting read beats.
  task automatic run(input int stall_word, input int stall_n, input logic [7:0] hold_exp);
    int st = 0;
    bit seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin seen = 1; break; end
      tick();
      if (req_ready) nrdy++;
      if (ws) wc++;
      wdata = wq[wc % 16];
      if (rvalid) begin
        if (rc == stall_word && st < stall_n) begin
          rready = 1'b0;
          st++;
          chk("rdata_hold", rdata, hold_exp);
        end else begin
          rready = 1'b1;
          got[rc % 16] = rdata;
          rc++;
        end
      end
    end
    chk("done_seen", seen, 1);
    tdone = cyc;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    wvalid = 0; wdata = 0; rready = 0; wc = 0; rc = 0; nrdy = 0;
    #12;
    chk("rst_ctrl", {req_ready, busy, done, wsa, ws, we, wready, rvalid}, 8'b1000_0000);
    chk("rst_buses", {bas, bis, rdata}, 24'h0);
    @(posedge clk); #1 reset = 1'b0;
    tick();

    // single write 0xA5 -> 0x3C, then read it back
    s_wsa = n_wsa; s_ws = n_ws; s_we = n_we; s_done = n_done;
    wvalid = 1'b1; wdata = 8'hA5;
    start(1'b1, 8'h3C, 4'd0, 0);
    chk("w1_busy", {busy, req_ready}, 2'b10);
    tick(); chk("w1_wready", wready, 1); chk("w1_bas_wdata", bas, 8'h3C);
    tick(); chk("w1_ws", ws, 1); chk("w1_bis", bis, 8'hA5); chk("w1_bas_wstb", bas, 8'h3C);
    wvalid = 1'b0;
    tick(); chk("w1_ws_hold", ws, 0); chk("w1_bis_hold", bis, 8'hA5); chk("w1_bas_hold", bas, 8'h3C);
    tick(); chk("w1_done", done, 1); chk("w1_bas_done", bas, 8'h00); chk("w1_bis_done", bis, 8'h00);
    tick(); chk("w1_idle", {req_ready, busy, done}, 3'b100);
    chk("w1_mem", mem[8'h3C], 8'hA5);
    rready = 1'b1;
    start(1'b0, 8'h3C, 4'd0, 0);
    tick(); chk("r1_we", {we, rvalid}, 2'b10); chk("r1_bas", bas, 8'h3C);
    tick(); chk("r1_rvalid", {we, rvalid}, 2'b01); chk("r1_rdata", rdata, 8'hA5);
    tick(); chk("r1_done", done, 1);
    tick();
    chk("t1_wsa_cnt", n_wsa - s_wsa, 2);
    chk("t1_ws_cnt", n_ws - s_ws, 1);
    chk("t1_we_cnt", n_we - s_we, 1);
    chk("t1_done_cnt", n_done - s_done, 2);

    // burst write with address wrap; duration counts accept cycle through DONE
    wq[0] = 8'd1; wq[1] = 8'd2; wq[2] = 8'd3; wq[3] = 8'd4;
    wc = 0; wdata = wq[0]; wvalid = 1'b1; s_done = n_done;
    start(1'b1, 8'hFE, 4'd3, 0);
    run(-1, 0, 8'h00);
    chk("wrap_cycles", tdone - tacc + 1, 18);
    chk("wrap_fe", mem[8'hFE], 8'd1);
    chk("wrap_ff", mem[8'hFF], 8'd2);
    chk("wrap_00", mem[8'h00], 8'd3);
    chk("wrap_01", mem[8'h01], 8'd4);
    chk("wrap_done_cnt", n_done - s_done, 1);

    // preload 0x10..0x12, then read burst with 3 stall cycles on word 2
    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
    wc = 0; wdata = wq[0];
    start(1'b1, 8'h10, 4'd2, 0);
    run(-1, 0, 8'h00);
    wvalid = 1'b0; rc = 0; rready = 1'b1;
    start(1'b0, 8'h10, 4'd2, 0);
    run(1, 3, 8'h22);
    chk("rb_cnt", rc, 3);
    chk("rb_d0", got[0], 8'h11);
    chk("rb_d1", got[1], 8'h22);
    chk("rb_d2", got[2], 8'h33);

    // write stall: wvalid held low while waiting in WDATA
    wq[0] = 8'h5A; wc = 0; wdata = wq[0]; wvalid = 1'b0;
    start(1'b1, 8'h40, 4'd0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ws", ws, 0);
      chk("stall_bas", bas, 8'h40);
    end
    chk("stall_wready", wready, 1);
    wvalid = 1'b1;
    run(-1, 0, 8'h00);
    wvalid = 1'b0;
    chk("stall_mem", mem[8'h40], 8'h5A);

    // async reset while the first word of a 4-word read waits in RRESP
    rready = 1'b0; s_done = n_done;
    start(1'b0, 8'h10, 4'd3, 0);
    for (int k = 0; k < 20 && !rvalid; k++) tick();
    chk("rst_rresp_reached", rvalid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", {wsa, ws, we, busy, rvalid, done}, 6'b0);
    chk("rst_mid_ready", req_ready, 1);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("rst_no_done", n_done - s_done, 0);
    rready = 1'b1; rc = 0;
    start(1'b0, 8'h3C, 4'd0, 0);
    run(-1, 0, 8'h00);
    chk("rst_after_rdata", got[0], 8'hA5);

    // second request held during a burst is accepted only once IDLE returns
    rc = 0; nrdy = 0; rready = 1'b1;
    start(1'b0, 8'hFE, 4'd1, 1);
    req_addr = 8'h00; req_len = 4'd0;
    run(-1, 0, 8'h00);
    chk("busy_ready_low", nrdy, 0);
    chk("busy_d0", got[0], 8'd1);
    chk("busy_d1", got[1], 8'd2);
    chk("busy_idle_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("busy_second_bas", bas, 8'h00);
    chk("busy_second_wsa", {wsa, busy}, 2'b11);
    rc = 0;
    run(-1, 0, 8'h00);
    chk("busy_second_rdata", got[0], 8'd3);

    chk("strobe_excl", n_excl, 0);
    chk("we_in_rresp", n_werr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
